// File: rtl/run_monitor_pkg.sv
// Shared encodings for the run monitor: verdict states and failure causes.
package run_monitor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_XINSTR   = 2'd1,
      CAUSE_BADWRITE = 2'd2,
      CAUSE_TIMEOUT  = 2'd3
   } cause_t;

endpackage

// File: rtl/run_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_q <= '0;
      end else if (inc && (r_q != '1)) begin
         r_q <= r_q + W'(1);
      end
   end

   assign q = r_q;

endmodule

// File: rtl/run_monitor.sv
// Pass/fail monitor for the multicycle core: sticky verdict, run counters and first-fail capture.
module run_monitor
   import run_monitor_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned CYC_W     = 16,
   parameter int unsigned TIMEOUT   = 1000,
   parameter int unsigned PASS_ADR  = 128,
   parameter int unsigned PASS_DATA = 254,
   parameter int unsigned ALLOW_ADR = 80,
   parameter bit          STRICT    = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] instr,
   input  logic             instr_fetch,
   input  logic             mem_write,
   input  logic [WIDTH-1:0] adr,
   input  logic [WIDTH-1:0] write_data,
   output logic [2:0]       state,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [1:0]       fail_cause,
   output logic [WIDTH-1:0] fail_adr,
   output logic [CYC_W-1:0] cycle_count,
   output logic [CYC_W-1:0] instr_count
);

   localparam logic [WIDTH-1:0] LP_PASS_ADR  = WIDTH'(PASS_ADR);
   localparam logic [WIDTH-1:0] LP_PASS_DATA = WIDTH'(PASS_DATA);
   localparam logic [WIDTH-1:0] LP_ALLOW_ADR = WIDTH'(ALLOW_ADR);
   localparam int unsigned      LP_TO_LAST   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   state_t           r_state;
   cause_t           r_cause;
   logic [WIDTH-1:0] r_fail_adr;
   logic             r_done;
   logic             r_pass;
   logic             r_fail;

   state_t           w_next_state;
   cause_t           w_next_cause;
   logic [WIDTH-1:0] w_next_fail_adr;
   logic             w_clear;
   logic             w_in_run;
   logic             w_xinstr;
   logic             w_pass_wr;
   logic             w_bad_wr;
   logic             w_timeout;
   logic [CYC_W-1:0] w_cycle_count;
   logic [CYC_W-1:0] w_instr_count;

   // X detection only has meaning in a four-state simulator; hardware never sees X.
`ifndef SYNTHESIS
   assign w_xinstr = $isunknown(instr);
`else
   assign w_xinstr = 1'b0;
`endif

   assign w_in_run  = (r_state == ST_RUN);
   assign w_pass_wr = mem_write && (adr == LP_PASS_ADR) && (write_data == LP_PASS_DATA);
   assign w_bad_wr  = mem_write && STRICT && (adr != LP_PASS_ADR) && (adr != LP_ALLOW_ADR);
   assign w_timeout = (TIMEOUT != 0) && (32'(w_cycle_count) == LP_TO_LAST);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_next_state    = r_state;
      w_next_cause    = r_cause;
      w_next_fail_adr = r_fail_adr;
      w_clear         = 1'b0;
      unique case (r_state)
         ST_RUN: begin
            if (w_xinstr) begin
               w_next_state = ST_FAIL;
               w_next_cause = CAUSE_XINSTR;
            end else if (w_pass_wr) begin
               w_next_state = ST_PASS;
            end else if (w_bad_wr) begin
               w_next_state    = ST_FAIL;
               w_next_cause    = CAUSE_BADWRITE;
               w_next_fail_adr = adr;
            end else if (w_timeout) begin
               w_next_state = ST_TIMEOUT;
               w_next_cause = CAUSE_TIMEOUT;
            end
         end
         ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
            if (start) begin
               w_next_state    = ST_RUN;
               w_next_cause    = CAUSE_NONE;
               w_next_fail_adr = '0;
               w_clear         = 1'b1;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cause    <= CAUSE_NONE;
         r_fail_adr <= '0;
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_fail     <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_cause    <= w_next_cause;
         r_fail_adr <= w_next_fail_adr;
         r_done     <= (w_next_state == ST_PASS) || (w_next_state == ST_FAIL) ||
                       (w_next_state == ST_TIMEOUT);
         r_pass     <= (w_next_state == ST_PASS);
         r_fail     <= (w_next_state == ST_FAIL) || (w_next_state == ST_TIMEOUT);
      end
   end

   sat_counter #(.W(CYC_W)) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (w_clear),
      .inc   (w_in_run),
      .q     (w_cycle_count)
   );

   sat_counter #(.W(CYC_W)) u_instr_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (w_clear),
      .inc   (w_in_run && instr_fetch),
      .q     (w_instr_count)
   );

   assign state       = r_state;
   assign done        = r_done;
   assign pass        = r_pass;
   assign fail        = r_fail;
   assign fail_cause  = r_cause;
   assign fail_adr    = r_fail_adr;
   assign cycle_count = w_cycle_count;
   assign instr_count = w_instr_count;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: a strict 16-bit-counter instance with TIMEOUT=50 and a
// lax (STRICT=0) instance with 4-bit counters and no timeout, both driven by the same inputs.
module tb_run_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] instr;
   logic        instr_fetch;
   logic        mem_write;
   logic [31:0] adr;
   logic [31:0] write_data;

   logic [2:0]  m_state, l_state;
   logic        m_done, m_pass, m_fail, l_done, l_pass, l_fail;
   logic [1:0]  m_cause, l_cause;
   logic [31:0] m_fail_adr, l_fail_adr;
   logic [15:0] m_cycle, m_instr;
   logic [3:0]  l_cycle, l_instr;

   int checks = 0;
   int errors = 0;
   logic x_capable;
   logic [31:0] probe;

   always #5 clk = ~clk;

   run_monitor #(.TIMEOUT(50)) u_dut (
      .clk(clk), .reset(reset), .start(start), .instr(instr), .instr_fetch(instr_fetch),
      .mem_write(mem_write), .adr(adr), .write_data(write_data),
      .state(m_state), .done(m_done), .pass(m_pass), .fail(m_fail), .fail_cause(m_cause),
      .fail_adr(m_fail_adr), .cycle_count(m_cycle), .instr_count(m_instr)
   );

   run_monitor #(.CYC_W(4), .TIMEOUT(0), .STRICT(1'b0)) u_lax (
      .clk(clk), .reset(reset), .start(start), .instr(instr), .instr_fetch(instr_fetch),
      .mem_write(mem_write), .adr(adr), .write_data(write_data),
      .state(l_state), .done(l_done), .pass(l_pass), .fail(l_fail), .fail_cause(l_cause),
      .fail_adr(l_fail_adr), .cycle_count(l_cycle), .instr_count(l_instr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the edge they were updated on.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      mem_write  = 1'b1;
      adr        = a;
      write_data = d;
      tick();
      mem_write  = 1'b0;
   endtask

   initial begin
      probe     = 'x;
      x_capable = $isunknown(probe);

      reset = 1'b1; start = 1'b0; instr = '0; instr_fetch = 1'b0;
      mem_write = 1'b0; adr = '0; write_data = '0;
      tick(2);
      reset = 1'b0;
      tick(5);
      check("idle_state", 32'(m_state), 0);
      check("idle_done", 32'(m_done), 0);
      check("idle_cycle", 32'(m_cycle), 0);
      check("idle_instr", 32'(m_instr), 0);
      check("idle_cause", 32'(m_cause), 0);
      check("idle_fail_adr", m_fail_adr, 0);

      // Start: RUN one edge later, then 20 RUN cycles with 7 fetches, pass write on cycle 20.
      start = 1'b1; tick(); start = 1'b0;
      check("start_state", 32'(m_state), 1);
      check("start_cycle", 32'(m_cycle), 0);
      for (int i = 0; i < 20; i++) begin
         instr_fetch = (i < 7);
         tick();
      end
      instr_fetch = 1'b0;
      wr(32'd128, 32'd254);
      check("pass_state", 32'(m_state), 2);
      check("pass_pass", 32'(m_pass), 1);
      check("pass_done", 32'(m_done), 1);
      check("pass_fail", 32'(m_fail), 0);
      check("pass_instr", 32'(m_instr), 7);
      check("pass_cycle", 32'(m_cycle), 21);
      check("lax_pass_state", 32'(l_state), 2);
      check("lax_cycle_sat", 32'(l_cycle), 15);
      check("lax_instr", 32'(l_instr), 7);

      // Terminal state is sticky against further fetches and bad writes.
      instr_fetch = 1'b1;
      wr(32'd200, 32'd0);
      tick(2);
      instr_fetch = 1'b0;
      check("sticky_pass_state", 32'(m_state), 2);
      check("sticky_pass_cycle", 32'(m_cycle), 21);
      check("sticky_pass_instr", 32'(m_instr), 7);

      // Restart from PASS clears counters; allowed write, wrong-data pass write, then bad write.
      start = 1'b1; tick(); start = 1'b0;
      check("restart_state", 32'(m_state), 1);
      check("restart_cycle", 32'(m_cycle), 0);
      check("restart_instr", 32'(m_instr), 0);
      wr(32'd80, 32'd5);
      check("allow_no_fail", 32'(m_state), 1);
      wr(32'd128, 32'd253);
      check("wrong_data_no_pass", 32'(m_state), 1);
      wr(32'd200, 32'd7);
      check("bad_state", 32'(m_state), 3);
      check("bad_fail", 32'(m_fail), 1);
      check("bad_pass", 32'(m_pass), 0);
      check("bad_cause", 32'(m_cause), 2);
      check("bad_fail_adr", m_fail_adr, 200);
      check("bad_cycle", 32'(m_cycle), 3);
      check("lax_no_fail", 32'(l_state), 1);
      check("lax_fail_flag", 32'(l_fail), 0);

      // FAIL is sticky against a later pass write; lax instance takes the pass.
      wr(32'd128, 32'd254);
      check("sticky_fail_state", 32'(m_state), 3);
      check("sticky_fail_adr", m_fail_adr, 200);
      check("lax_late_pass", 32'(l_state), 2);

      // Restart from FAIL clears capture; X on instr together with the pass write.
      start = 1'b1; tick(); start = 1'b0;
      check("restart2_cause", 32'(m_cause), 0);
      check("restart2_fail_adr", m_fail_adr, 0);
      instr = 32'hxxxx_0000;
      wr(32'd128, 32'd254);
      instr = '0;
      if (x_capable) begin
         check("xinstr_state", 32'(m_state), 3);
         check("xinstr_cause", 32'(m_cause), 1);
         check("xinstr_pass", 32'(m_pass), 0);
      end else begin
         // Two-state simulation cannot carry X, so the pass write decides.
         check("xinstr_state", 32'(m_state), 2);
         check("xinstr_cause", 32'(m_cause), 0);
         check("xinstr_pass", 32'(m_pass), 1);
      end

      // Timeout: 49 quiet RUN cycles stay in RUN, the 50th enters TIMEOUT.
      start = 1'b1; tick(); start = 1'b0;
      tick(49);
      check("pre_timeout_state", 32'(m_state), 1);
      check("pre_timeout_cycle", 32'(m_cycle), 49);
      tick();
      check("timeout_state", 32'(m_state), 4);
      check("timeout_cause", 32'(m_cause), 3);
      check("timeout_fail", 32'(m_fail), 1);
      check("timeout_done", 32'(m_done), 1);
      check("timeout_cycle", 32'(m_cycle), 50);
      check("lax_no_timeout", 32'(l_state), 1);
      check("lax_cycle_hold", 32'(l_cycle), 15);

      // start held through RUN is ignored; reset wins over start and a pass write.
      start = 1'b1;
      tick(3);
      check("start_ignored_state", 32'(m_state), 1);
      check("start_ignored_cycle", 32'(m_cycle), 2);
      reset = 1'b1;
      wr(32'd128, 32'd254);
      reset = 1'b0; start = 1'b0;
      check("reset_run_state", 32'(m_state), 0);
      check("reset_run_cycle", 32'(m_cycle), 0);
      check("reset_run_done", 32'(m_done), 0);
      check("reset_run_pass", 32'(m_pass), 0);
      check("lax_reset_state", 32'(l_state), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
